// File: rtl/program_sequencer_if.sv
// Signal bundle between the program sequencer, the decoder and the program loader.
// The slave modport is the sequencer's view; the master modport is the surrounding core's view.
interface program_sequencer_if;
  logic       jmp;
  logic       jmp_nz;
  logic       dont_jmp;
  logic [3:0] ir_nibble;
  logic       load_req;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] pm_addr;
  logic       pm_we;
  logic [7:0] pm_wdata;
  logic [7:0] pc;
  logic [7:0] from_pc;
  logic       core_reset;

  modport slave (
    input  jmp, jmp_nz, dont_jmp, ir_nibble, load_req, ld_valid, ld_data,
    output ld_ready, pm_addr, pm_we, pm_wdata, pc, from_pc, core_reset
  );

  modport master (
    output jmp, jmp_nz, dont_jmp, ir_nibble, load_req, ld_valid, ld_data,
    input  ld_ready, pm_addr, pm_we, pm_wdata, pc, from_pc, core_reset
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter and fetch-address generator with a byte-serial program loader.
// The loader holds the rest of the core in reset and restarts execution at address 0.
module program_sequencer #(
  parameter logic [7:0] LAST_ADDR = 8'hFF
) (
  input logic                  clk,
  input logic                  sync_reset,
  program_sequencer_if.slave   bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_pc;
  logic [7:0] r_from_pc;
  logic [7:0] r_wptr;

  logic [7:0] w_target;
  logic       w_take;
  logic [7:0] w_pm_addr;
  logic       w_pm_we;
  logic       w_ld_ready;
  logic       w_last_write;

  assign w_target = {bus.ir_nibble, 4'h0};
  // The edge that enters LOAD ignores the jump inputs.
  assign w_take = !bus.load_req && (bus.jmp || (bus.jmp_nz && !bus.dont_jmp));
  assign w_last_write = bus.ld_valid && (r_wptr == LAST_ADDR);

  always_comb begin
    w_pm_addr  = r_pc + 8'd1;
    w_pm_we    = 1'b0;
    w_ld_ready = 1'b0;
    if (sync_reset) begin
      w_pm_addr = 8'h00;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_take) w_pm_addr = w_target;
        end
        S_LOAD: begin
          w_pm_addr  = r_wptr;
          w_pm_we    = bus.ld_valid;
          w_ld_ready = 1'b1;
        end
        default: begin
          w_pm_addr = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state   <= S_RUN;
      r_pc      <= 8'h00;
      r_from_pc <= 8'h00;
      r_wptr    <= 8'h00;
    end else begin
      case (r_state)
        S_RUN: begin
          r_pc <= w_pm_addr;
          if (w_take) r_from_pc <= r_pc;
          if (bus.load_req) begin
            r_state <= S_LOAD;
            r_wptr  <= 8'h00;
          end
        end
        S_LOAD: begin
          if (bus.ld_valid) r_wptr <= r_wptr + 8'd1;
          if (!bus.load_req || w_last_write) r_state <= S_FLUSH;
        end
        default: begin
          // Decoder captures pm[0] during this cycle, so RUN resumes fetching from 1.
          r_pc    <= 8'h00;
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign bus.pm_addr    = w_pm_addr;
  assign bus.pm_we      = w_pm_we;
  assign bus.pm_wdata   = bus.ld_data;
  assign bus.ld_ready   = w_ld_ready;
  assign bus.pc         = r_pc;
  assign bus.from_pc    = r_from_pc;
  assign bus.core_reset = sync_reset || (r_state != S_RUN);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: jumps, wrap-around, loading and its exits.
module tb_program_sequencer;
  logic clk = 1'b0;
  logic sync_reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  program_sequencer_if a ();
  program_sequencer_if b ();

  program_sequencer dut_a (.clk(clk), .sync_reset(sync_reset), .bus(a));
  program_sequencer #(.LAST_ADDR(8'h03)) dut_b (.clk(clk), .sync_reset(sync_reset), .bus(b));

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    sync_reset = 1'b1;
    a.jmp = 0; a.jmp_nz = 0; a.dont_jmp = 0; a.ir_nibble = 0;
    a.load_req = 0; a.ld_valid = 0; a.ld_data = 0;
    b.jmp = 0; b.jmp_nz = 0; b.dont_jmp = 0; b.ir_nibble = 0;
    b.load_req = 0; b.ld_valid = 0; b.ld_data = 0;

    // Reset
    nxt(); settle();
    chk("rst_pm_addr", a.pm_addr, 8'h00);
    chk("rst_core_reset", {7'd0, a.core_reset}, 8'h01);
    chk("rst_ld_ready", {7'd0, a.ld_ready}, 8'h00);
    chk("rst_pm_we", {7'd0, a.pm_we}, 8'h00);
    nxt();
    sync_reset = 1'b0;
    settle();
    chk("rst_pc", a.pc, 8'h00);
    chk("rst_from_pc", a.from_pc, 8'h00);
    chk("rel_core_reset", {7'd0, a.core_reset}, 8'h00);

    // Free run
    for (int i = 1; i <= 5; i++) begin
      chk("run_pm_addr", a.pm_addr, 8'(i));
      chk("run_pc", a.pc, 8'(i - 1));
      nxt(); settle();
    end

    // Unconditional jump at pc=05
    chk("pre_jmp_pc", a.pc, 8'h05);
    a.jmp = 1; a.ir_nibble = 4'h3; settle();
    chk("jmp_pm_addr", a.pm_addr, 8'h30);
    nxt(); a.jmp = 0; settle();
    chk("jmp_pc", a.pc, 8'h30);
    chk("jmp_from_pc", a.from_pc, 8'h05);
    chk("jmp_next_addr", a.pm_addr, 8'h31);

    // Conditional jump taken
    a.jmp_nz = 1; a.ir_nibble = 4'hA; a.dont_jmp = 0; settle();
    chk("jnz_take_addr", a.pm_addr, 8'hA0);
    nxt(); a.jmp_nz = 0; settle();
    chk("jnz_take_pc", a.pc, 8'hA0);
    chk("jnz_take_from", a.from_pc, 8'h30);

    // Conditional jump suppressed by zero flag
    a.jmp_nz = 1; a.ir_nibble = 4'h5; a.dont_jmp = 1; settle();
    chk("jnz_skip_addr", a.pm_addr, 8'hA1);
    nxt(); a.jmp_nz = 0; a.dont_jmp = 0; settle();
    chk("jnz_skip_pc", a.pc, 8'hA1);
    chk("jnz_skip_from", a.from_pc, 8'h30);

    // Both jump inputs: jmp wins even with dont_jmp set
    a.jmp = 1; a.jmp_nz = 1; a.dont_jmp = 1; a.ir_nibble = 4'hF; settle();
    chk("both_addr", a.pm_addr, 8'hF0);
    nxt(); a.jmp = 0; a.jmp_nz = 0; a.dont_jmp = 0; settle();
    chk("both_pc", a.pc, 8'hF0);
    chk("both_from", a.from_pc, 8'hA1);

    // Wrap-around
    for (int i = 0; i < 15; i++) nxt();
    settle();
    chk("wrap_pc", a.pc, 8'hFF);
    chk("wrap_addr", a.pm_addr, 8'h00);
    nxt(); settle();
    chk("wrap_pc0", a.pc, 8'h00);
    chk("wrap_addr1", a.pm_addr, 8'h01);

    // Enter LOAD; jump on the entry edge is ignored
    a.load_req = 1; a.jmp = 1; a.ir_nibble = 4'h7; settle();
    chk("ent_addr", a.pm_addr, 8'h01);
    chk("ent_ready", {7'd0, a.ld_ready}, 8'h00);
    nxt(); a.jmp = 0;
    a.ld_valid = 1; a.ld_data = 8'h11; settle();
    chk("ld0_pc", a.pc, 8'h01);
    chk("ld0_from", a.from_pc, 8'hA1);
    chk("ld0_ready", {7'd0, a.ld_ready}, 8'h01);
    chk("ld0_core_reset", {7'd0, a.core_reset}, 8'h01);
    chk("ld0_we", {7'd0, a.pm_we}, 8'h01);
    chk("ld0_addr", a.pm_addr, 8'h00);
    chk("ld0_data", a.pm_wdata, 8'h11);
    nxt(); a.ld_data = 8'h22; settle();
    chk("ld1_we", {7'd0, a.pm_we}, 8'h01);
    chk("ld1_addr", a.pm_addr, 8'h01);
    chk("ld1_data", a.pm_wdata, 8'h22);
    nxt(); a.ld_valid = 0; settle();
    chk("idle_we", {7'd0, a.pm_we}, 8'h00);
    chk("idle_ready", {7'd0, a.ld_ready}, 8'h01);
    nxt(); a.ld_valid = 1; a.ld_data = 8'h33; settle();
    chk("ld2_we", {7'd0, a.pm_we}, 8'h01);
    chk("ld2_addr", a.pm_addr, 8'h02);
    chk("ld2_data", a.pm_wdata, 8'h33);
    nxt(); a.ld_valid = 0; a.load_req = 0; settle();
    chk("drop_we", {7'd0, a.pm_we}, 8'h00);
    chk("drop_pc", a.pc, 8'h01);
    nxt(); settle();
    chk("flush_addr", a.pm_addr, 8'h00);
    chk("flush_we", {7'd0, a.pm_we}, 8'h00);
    chk("flush_ready", {7'd0, a.ld_ready}, 8'h00);
    chk("flush_core_reset", {7'd0, a.core_reset}, 8'h01);
    nxt(); settle();
    chk("resume_addr", a.pm_addr, 8'h01);
    chk("resume_pc", a.pc, 8'h00);
    chk("resume_core_reset", {7'd0, a.core_reset}, 8'h00);

    // Byte on the same cycle load_req falls
    a.load_req = 1;
    nxt(); a.ld_valid = 1; a.ld_data = 8'h44; settle();
    chk("fall0_addr", a.pm_addr, 8'h00);
    nxt(); a.load_req = 0; a.ld_data = 8'h55; settle();
    chk("fall1_we", {7'd0, a.pm_we}, 8'h01);
    chk("fall1_addr", a.pm_addr, 8'h01);
    chk("fall1_data", a.pm_wdata, 8'h55);
    nxt(); a.ld_valid = 0; settle();
    chk("fall_flush_addr", a.pm_addr, 8'h00);
    chk("fall_flush_ready", {7'd0, a.ld_ready}, 8'h00);
    nxt(); settle();
    chk("fall_resume_addr", a.pm_addr, 8'h01);

    // Reset in the middle of a load
    a.load_req = 1;
    nxt(); a.ld_valid = 1; a.ld_data = 8'h66; settle();
    chk("mid0_we", {7'd0, a.pm_we}, 8'h01);
    nxt(); a.ld_data = 8'h77; sync_reset = 1; settle();
    chk("mid_rst_we", {7'd0, a.pm_we}, 8'h00);
    chk("mid_rst_ready", {7'd0, a.ld_ready}, 8'h00);
    chk("mid_rst_addr", a.pm_addr, 8'h00);
    nxt(); sync_reset = 0; a.load_req = 0; settle();
    chk("mid_after_we", {7'd0, a.pm_we}, 8'h00);
    chk("mid_after_pc", a.pc, 8'h00);
    chk("mid_after_addr", a.pm_addr, 8'h01);
    chk("mid_after_core_reset", {7'd0, a.core_reset}, 8'h00);
    a.ld_valid = 0;

    // Automatic exit at LAST_ADDR=03 with load_req held high
    b.load_req = 1;
    nxt(); b.ld_valid = 1;
    for (int k = 0; k < 4; k++) begin
      b.ld_data = 8'(8'hB0 + k); settle();
      chk("auto_we", {7'd0, b.pm_we}, 8'h01);
      chk("auto_addr", b.pm_addr, 8'(k));
      chk("auto_data", b.pm_wdata, 8'(8'hB0 + k));
      nxt();
    end
    settle();
    chk("auto_flush_we", {7'd0, b.pm_we}, 8'h00);
    chk("auto_flush_ready", {7'd0, b.ld_ready}, 8'h00);
    chk("auto_flush_addr", b.pm_addr, 8'h00);
    nxt(); settle();
    chk("auto_run_core_reset", {7'd0, b.core_reset}, 8'h00);
    chk("auto_run_ready", {7'd0, b.ld_ready}, 8'h00);
    chk("auto_run_addr", b.pm_addr, 8'h01);
    b.load_req = 0; b.ld_valid = 0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
